// File: rtl/button_debounce.sv
// Push-button conditioner: optional two-flop synchroniser, stability counter and
// four-state qualify FSM. Define BTN_DEBOUNCE_SYNC_EN to insert the synchroniser.
module button_debounce #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   typedef enum logic [1:0] {
      IDLE_LOW,
      WAIT_HIGH,
      IDLE_HIGH,
      WAIT_LOW
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             d;

`ifdef BTN_DEBOUNCE_SYNC_EN
   logic sync1, sync2;

   // NOTE: sequential state uses non-blocking assignments so sync2 takes the
   // previous sync1, forming a true two-stage pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn_in;
         sync2 <= sync1;
      end
   end

   assign d = sync2;
`else
   assign d = btn_in;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE_LOW;
         cnt         <= '0;
         btn_level   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
      end else begin
         // NOTE: strobes default low every cycle; only an accepted change raises one.
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
         unique case (state)
            IDLE_LOW: begin
               cnt <= '0;
               if (d) state <= WAIT_HIGH;
            end
            WAIT_HIGH: begin
               if (!d) begin
                  state <= IDLE_LOW;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state     <= IDLE_HIGH;
                  cnt       <= '0;
                  btn_level <= 1'b1;
                  btn_press <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            IDLE_HIGH: begin
               cnt <= '0;
               if (!d) state <= WAIT_LOW;
            end
            WAIT_LOW: begin
               if (d) begin
                  state <= IDLE_HIGH;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state       <= IDLE_LOW;
                  cnt         <= '0;
                  btn_level   <= 1'b0;
                  btn_release <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE_LOW;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
